dcache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the external memory port.
- MEM issues one word read or write per request.
- Read hits return in one cycle. Misses refill a 4-word line over a req/ack memory handshake.
- Writes always go through to memory, and update the cached copy on a hit.

---
 rtl/dcache.sv | 154 +++++++++++++++
 tb/tb_dcache.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Misses refill one word per req/ack beat; writes always go out to memory.
module dcache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit,
  output logic        done,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 28 - IDX;

  typedef enum logic [1:0] {IDLE, REFILL, WMEM} state_t;
  typedef struct packed {
    logic [31:2] addr;
    logic        whit;
  } req_t;

  state_t state, nxt;
  req_t   rq;
  logic [2:0] cnt;
  logic       fin;   // high during the done cycle of a miss or write

  logic [LINES-1:0]            valid;
  logic [TW-1:0]               tags [LINES];
  logic [WORDS-1:0][31:0]      data [LINES];

  logic [IDX-1:0] aidx, ridx;
  logic [TW-1:0]  atag, rtag;
  logic [1:0]     aoff, roff;
  logic           lhit, beat, unused_lsb;

  assign aidx = address[3+IDX:4];
  assign atag = address[31:4+IDX];
  assign aoff = address[3:2];
  assign ridx = rq.addr[3+IDX:4];
  assign rtag = rq.addr[31:4+IDX];
  assign roff = rq.addr[3:2];
  assign lhit = valid[aidx] && (tags[aidx] == atag);
  assign beat = (state == REFILL) && mem_req && mem_ack && !fin;
  assign busy = (state != IDLE);
  assign unused_lsb = ^address[1:0];

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (write) nxt = WMEM;
               else if (read && !lhit) nxt = REFILL;
      REFILL:  if (fin) nxt = IDLE;
      WMEM:    if (fin) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      hit       <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      valid     <= '0;
      cnt       <= '0;
      fin       <= 1'b0;
      rq        <= '0;
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      case (state)
        IDLE: begin
          if (write) begin
            rq        <= '{addr: address[31:2], whit: lhit};
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {address[31:2], 2'b00};
            mem_wdata <= data_in;
          end else if (read) begin
            rq <= '{addr: address[31:2], whit: lhit};
            if (lhit) begin
              done     <= 1'b1;
              hit      <= 1'b1;
              data_out <= data[aidx][aoff];
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= 1'b0;
              mem_addr    <= {address[31:4], 4'b0000};
              cnt         <= '0;
              valid[aidx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (fin) begin
            fin <= 1'b0;
          end else if (beat) begin
            mem_req <= 1'b0;
            cnt     <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              fin         <= 1'b1;
              valid[ridx] <= 1'b1;
              done        <= 1'b1;
              data_out    <= (roff == 2'd3) ? mem_rdata : data[ridx][roff];
            end
          end else if (!mem_req) begin
            // one idle cycle after each ack, then issue the next beat
            mem_req  <= 1'b1;
            mem_addr <= {rq.addr[31:4], cnt[1:0], 2'b00};
          end
        end
        WMEM: begin
          if (fin) begin
            fin <= 1'b0;
          end else if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            fin     <= 1'b1;
            done    <= 1'b1;
            hit     <= rq.whit;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == IDLE && write && lhit)
      data[aidx][aoff] <= data_in;
    if (beat) begin
      data[ridx][cnt[1:0]] <= mem_rdata;
      if (cnt == 3'd3) tags[ridx] <= rtag;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: memory responder model plus a scoreboard of
// expected done results, checked with immediate assertions.
module tb_dcache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] address = '0, data_in = '0;
  logic [31:0] data_out, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        hit, done, busy, mem_req, mem_we;
  logic        mem_ack = 1'b0;

  dcache #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .data_in(data_in), .data_out(data_out), .hit(hit), .done(done), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        h;
    logic        chkd;
    logic        b;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0, nerr = 0;
  int          nbeats = 0, nwr = 0;
  logic [31:0] waddr = '0;
  logic [31:0] baddr [4];
  logic [31:0] mm [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : (a ^ 32'hA5A5_0000);
  endfunction

  // memory: ack one cycle after each request is seen, drop ack the next cycle
  always @(negedge clk) begin
    if (reset) mem_ack = 1'b0;
    else if (mem_ack) mem_ack = 1'b0;
    else if (mem_req) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        mm[mem_addr] = mem_wdata;
        waddr = mem_addr;
        nwr++;
      end else begin
        mem_rdata = rd(mem_addr);
        baddr[nbeats % 4] = mem_addr;
        nbeats++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chkd) chk("data_out", data_out, e.d);
        chk("hit", {31'd0, hit}, {31'd0, e.h});
        chk("busy_at_done", {31'd0, busy}, {31'd0, e.b});
      end
    end
  end

  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic push, input logic eh);
    int k = 0;
    while (busy && k < 300) begin @(negedge clk); k++; end
    if (busy) chk("issue_timeout", 32'd1, 32'd0);
    if (push) begin
      exp_t e;
      e.d = rd(a); e.h = eh; e.chkd = r && !w; e.b = !(r && !w && eh);
      sb.push_back(e);
    end
    read = r; write = w; address = a; data_in = d;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin @(negedge clk); k++; end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int b0, w0;

  initial begin
    mm[32'h40] = 32'h11; mm[32'h44] = 32'h22;
    mm[32'h48] = 32'h33; mm[32'h4C] = 32'h44;
    #1;
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_ctl", {26'd0, hit, done, busy, mem_req, mem_we, 1'b0}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // cold miss and refill
    b0 = nbeats;
    issue(1, 0, 32'h40, 0, 1, 0);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    drain();
    chk("refill_beats", nbeats - b0, 32'd4);
    chk("beat0_addr", baddr[0], 32'h40);
    chk("beat3_addr", baddr[3], 32'h4C);

    // hit after refill
    b0 = nbeats;
    issue(1, 0, 32'h48, 0, 1, 1);
    drain();
    chk("hit_no_beats", nbeats - b0, 32'd0);

    // write hit, then read it back
    w0 = nwr;
    issue(0, 1, 32'h44, 32'hDEAD_BEEF, 1, 1);
    drain();
    chk("wr_hit_count", nwr - w0, 32'd1);
    chk("wr_hit_addr", waddr, 32'h44);
    issue(1, 0, 32'h44, 0, 1, 1);
    drain();

    // write miss does not allocate
    w0 = nwr; b0 = nbeats;
    issue(0, 1, 32'h1000, 32'h1234_5678, 1, 0);
    drain();
    chk("wr_miss_count", nwr - w0, 32'd1);
    chk("wr_miss_addr", waddr, 32'h1000);
    issue(1, 0, 32'h1000, 0, 1, 0);
    drain();
    chk("no_alloc_beats", nbeats - b0, 32'd4);

    // aliasing on the same index
    b0 = nbeats;
    issue(1, 0, 32'h440, 0, 1, 0);
    drain();
    issue(1, 0, 32'h40, 0, 1, 0);
    drain();
    chk("alias_beats", nbeats - b0, 32'd8);

    // back-to-back hits
    b0 = nbeats;
    issue(1, 0, 32'h40, 0, 1, 1);
    issue(1, 0, 32'h44, 0, 1, 1);
    drain();
    chk("b2b_beats", nbeats - b0, 32'd0);

    // reset after two refill beats
    b0 = nbeats;
    issue(1, 0, 32'h80, 0, 0, 0);
    for (int k = 0; k < 100 && nbeats < b0 + 2; k++) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_ctl", {26'd0, hit, done, busy, mem_req, mem_we, 1'b0}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    b0 = nbeats;
    issue(1, 0, 32'h80, 0, 1, 0);
    drain();
    chk("rerefill_beats", nbeats - b0, 32'd4);

    // read and write together act as a write
    b0 = nbeats; w0 = nwr;
    issue(1, 1, 32'h200, 32'hCAFE_F00D, 1, 0);
    drain();
    chk("rw_writes", nwr - w0, 32'd1);
    chk("rw_beats", nbeats - b0, 32'd0);
    chk("rw_mem", rd(32'h200), 32'hCAFE_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
